// File: rtl/factorial_engine.sv
// factorial_engine: iterative SCALE * n! with overflow detection.
// One multiply per cycle; latency from accept to done is max(n,1) cycles.
// Build option FACT_SAT_EN: on overflow the accumulator saturates to all-ones
// instead of keeping the low R_W bits of the product.
module factorial_engine #(
    parameter int              N_W   = 4,
    parameter int              R_W   = 32,
    parameter longint unsigned SCALE = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic [R_W-1:0] result,
    output logic           ovf
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, state_nx;
    logic [N_W-1:0]   n_q;
    // One extra bit so the counter can reach 2^N_W and terminate for the largest n.
    logic [N_W:0]     i;
    logic [R_W-1:0]   acc;
    logic             flag;

    logic             accept, step, finish;
    logic [2*R_W-1:0] prod;
    logic             prod_ovf;
    logic [R_W-1:0]   acc_nx;

    // Full-width product; any bit above R_W means the true value no longer fits.
    assign prod     = (2*R_W)'(acc) * (2*R_W)'(i);
    assign prod_ovf = |prod[2*R_W-1:R_W];

`ifdef FACT_SAT_EN
    // Once saturated, stay pinned at all-ones for the rest of the operation.
    assign acc_nx = (flag || prod_ovf) ? '1 : prod[R_W-1:0];
`else
    assign acc_nx = prod[R_W-1:0];
`endif

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (i <= {1'b0, n_q}) begin
                    step = 1'b1;
                end else begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Datapath: capture operand, iterate the multiply, publish on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q    <= '0;
            i      <= '0;
            acc    <= '0;
            flag   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                n_q  <= n;
                acc  <= R_W'(SCALE);
                i    <= (N_W+1)'(2);
                flag <= 1'b0;
            end
            if (step) begin
                acc  <= acc_nx;
                i    <= i + (N_W+1)'(1);
                flag <= flag | prod_ovf;
            end
            if (finish) begin
                result <= acc;
                ovf    <= flag;
            end
        end
    end

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine (defaults N_W=4, R_W=32, SCALE=2).
// Inputs driven and outputs sampled on the falling edge.
module tb_factorial_engine;

    localparam int              N_W   = 4;
    localparam int              R_W   = 32;
    localparam longint unsigned SCALE = 2;
    localparam longint unsigned MASK  = (64'd1 << R_W) - 64'd1;

`ifdef FACT_SAT_EN
    localparam longint unsigned R13 = 64'hFFFF_FFFF;
    localparam longint unsigned R15 = 64'hFFFF_FFFF;
`else
    localparam longint unsigned R13 = 64'd3864107008;
    localparam longint unsigned R15 = 64'd4008620032;
`endif

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N_W-1:0] n     = '0;
    logic           busy, done, ovf;
    logic [R_W-1:0] result;

    int total = 0;
    int bad   = 0;

    factorial_engine #(.N_W(N_W), .R_W(R_W), .SCALE(SCALE)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              nv;
        longint unsigned res;
        logic            ov;
        int              lat;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact SCALE*n! in 64 bits (fits for n<=15), then the R_W view.
    function automatic void model(input int nv, output longint unsigned r, output logic o, output int lat);
        longint unsigned t;
        t = SCALE;
        for (int k = 2; k <= nv; k++) t = t * longint'(k);
        o = (t >> R_W) != 0;
`ifdef FACT_SAT_EN
        r = o ? MASK : t;
`else
        r = t & MASK;
`endif
        lat = (nv < 2) ? 1 : nv;
    endfunction

    // Called just after a falling edge; start is presented for exactly one edge.
    task automatic run_op(input string name, input int nv, input longint unsigned er,
                          input logic eo, input int el);
        int lat;
        start = 1'b1;
        n     = N_W'(nv);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 64);
        check({name, "_done"}, done, 1);
        check({name, "_lat"}, lat, el);
        check({name, "_res"}, result, er);
        check({name, "_ovf"}, ovf, eo);
        check({name, "_idle"}, busy, 0);
        @(negedge clk);
        check({name, "_pulse"}, done, 0);
        check({name, "_held"}, result, er);
    endtask

    initial begin
        vec_t            tbl [9];
        longint unsigned mr;
        logic            mo;
        int              ml, lat, nv;

        tbl[0] = '{5,  64'd240,       1'b0, 5};
        tbl[1] = '{0,  64'd2,         1'b0, 1};
        tbl[2] = '{1,  64'd2,         1'b0, 1};
        tbl[3] = '{2,  64'd4,         1'b0, 2};
        tbl[4] = '{3,  64'd12,        1'b0, 3};
        tbl[5] = '{12, 64'd958003200, 1'b0, 12};
        tbl[6] = '{13, R13,           1'b1, 13};
        tbl[7] = '{15, R15,           1'b1, 15};
        tbl[8] = '{6,  64'd1440,      1'b0, 6};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;

        // Table vectors; the first start lands on the edge right after reset drops
        for (int k = 0; k < 9; k++)
            run_op($sformatf("tbl%0d", k), tbl[k].nv, tbl[k].res, tbl[k].ov, tbl[k].lat);

        // Back-to-back: n=0 with start held, n=1 accepted in the done cycle
        start = 1'b1; n = 0;
        @(negedge clk);
        check("b2b_busy0", busy, 1);
        n = 1;
        @(negedge clk);
        check("b2b_done0", done, 1);
        check("b2b_res0", result, 2);
        check("b2b_ovf0", ovf, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy1", busy, 1);
        check("b2b_nodone", done, 0);
        @(negedge clk);
        check("b2b_done1", done, 1);
        check("b2b_res1", result, 2);
        check("b2b_ovf1", ovf, 0);
        @(negedge clk);

        // Protocol: start held and n scrambled throughout busy
        start = 1'b1; n = 6;
        @(negedge clk);
        check("prot_busy", busy, 1);
        n = N_W'($urandom_range(0, 15));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done) n = N_W'($urandom_range(0, 15));
        end while (!done && lat < 64);
        start = 1'b0;
        check("prot_done", done, 1);
        check("prot_lat", lat, 6);
        check("prot_res", result, 1440);
        check("prot_ovf", ovf, 0);
        @(negedge clk);
        check("prot_noqueue_busy", busy, 0);
        check("prot_noqueue_done", done, 0);

        // Reset in the 3rd cycle of n=9
        start = 1'b1; n = 9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_ovf", ovf, 0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
        end
        run_op("post_abort", 3, 12, 1'b0, 3);

        // Random operands against the reference model
        for (int k = 0; k < 30; k++) begin
            nv = $urandom_range(0, 15);
            model(nv, mr, mo, ml);
            run_op($sformatf("rnd%0d_n%0d", k, nv), nv, mr, mo, ml);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/factorial_engine.md
FACTORIAL_ENGINE -- requirements
Module: factorial_engine

Interface
REQ-001 Parameter N_W, default 4, operand width in bits (legal 2..8).
REQ-002 Parameter R_W, default 32, result width in bits (legal 8..64).
REQ-003 Parameter SCALE, default 2, constant pre-multiplier; result = SCALE * n! (legal 1..2^R_W-1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; accepted only when busy=0.
REQ-007 n  input  N_W  operand; sampled on the accepting edge only.
REQ-008 busy  output  1  high from the accepting edge until the completing edge.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  R_W  SCALE*n!; held until the next completion.
REQ-011 ovf  output  1  true result exceeded R_W bits; valid with done, held with result.

Function
REQ-012 States SHALL be IDLE and CALC, with busy=1 exactly in CALC.
REQ-013 In IDLE, start=1 at an edge SHALL accept: capture n, set acc=SCALE, set i=2, clear the internal overflow flag, and go to CALC.
REQ-014 start while busy=1 SHALL be ignored, with no queuing and no effect on n capture.
REQ-015 In CALC, when i<=n, an edge SHALL set acc=acc*i and i=i+1.
REQ-016 In CALC, when i>n, an edge SHALL load result=acc and ovf=flag, pulse done=1, and return to IDLE.
REQ-017 i SHALL be N_W+1 bits wide, so n=2^N_W-1 terminates without wrap.
REQ-018 Latency from the accepting edge to done SHALL be max(n,1) cycles: n=0 and n=1 take 1 cycle; otherwise n cycles.
REQ-019 0! SHALL be 1, so n=0 yields SCALE.
REQ-020 Each multiply SHALL form the full 2*R_W-bit product; any nonzero upper R_W bits SHALL set the flag, which stays sticky for the operation.
REQ-021 done SHALL be high for exactly one cycle and low in every other cycle.
REQ-022 start=1 in the same cycle that done=1 SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-023 result and ovf SHALL change only on a completing edge or on reset.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE with busy=0, done=0, result=0, ovf=0, and clear acc, i and the flag.
REQ-025 reset SHALL take priority over start and over any operation in progress; an aborted operation produces no done.
REQ-026 The first start SHALL be accepted at the edge after reset deasserts.

Configuration
REQ-027 Macro FACT_SAT_EN SHALL control overflow handling.
REQ-028 With FACT_SAT_EN defined, on overflow acc SHALL saturate to all-ones and remain all-ones until completion.
REQ-029 Without FACT_SAT_EN, acc SHALL keep the low R_W bits of the product (wrap).
REQ-030 ovf reporting and latency SHALL be identical in both builds.

Verification (defaults N_W=4, R_W=32, SCALE=2)
REQ-031 Basic: reset, then start with n=5 -> busy for 5 cycles, done pulses on the 5th edge, result=240, ovf=0.
REQ-032 Edge operands: n=0 then n=1 back-to-back -> each completes in 1 cycle with result=2 and ovf=0; n=12 -> result=958003200, ovf=0.
REQ-033 Overflow, wrap build: n=13 -> result=3864107008, ovf=1. Saturate build: n=13 -> result=0xFFFFFFFF, ovf=1. n=15 -> done after 15 cycles, ovf=1, no hang.
REQ-034 Protocol: start with n=6 held high throughout busy, and n changed mid-operation -> only one operation runs, result=1440. start asserted in the done cycle is accepted immediately.
REQ-035 Reset mid-operation: reset at the 3rd cycle of n=9 -> no done, all outputs 0 next cycle. A following start with n=3 -> result=12.
